chaos_lfsr_mixer: RTL and testbench

//  Downstream consumer of the 16-bit chaotic-map sample stream (Q1.15 logistic output).

---
 rtl/chaos_lfsr_mixer.sv | 168 ++++++++++++++++
 tb/tb_chaos_lfsr_mixer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/chaos_lfsr_mixer.sv
// chaos_lfsr_mixer: folds a chaotic Q1.15 sample stream into a Galois LFSR,
// packs one LFSR bit per accepted sample into bytes and queues them for output.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-low reset
//   chaos_in/valid     free-running sample stream from the map stage (no ready)
//   reseed             1-cycle pulse: reload LFSR and restart warm-up
//   out_data/valid     FIFO head byte (0 when empty) and non-empty flag
//   out_ready          consumer accepts the head byte when out_valid is high
//   warm               high once warm-up is complete (RUN state)
//   overrun            sticky: a completed byte was dropped on a full FIFO
module chaos_lfsr_mixer #(
    parameter int          LFSR_W     = 16,
    parameter logic [15:0] TAPS       = 16'hB400,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          INJ_BITS   = 4,
    parameter int          WARMUP     = 8,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] chaos_in,
    input  logic        chaos_valid,
    input  logic        reseed,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        warm,
    output logic        overrun
);

    localparam int WC_W  = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [LFSR_W-1:0] TAPS_W = LFSR_W'(TAPS);
    localparam logic [LFSR_W-1:0] SEED_W = LFSR_W'(SEED);
    localparam logic [WC_W-1:0]   WC_END = WC_W'(WARMUP - 1);
    localparam logic [PTR_W:0]    DEPTH  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {
        ST_WARM = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [WC_W-1:0]   warm_cnt_q, warm_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    // Only the seven most recent bits are kept; the eighth comes straight
    // from the current step when the byte is pushed.
    logic [6:0]        byte_sr_q, byte_sr_d;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [7:0]        mem_d [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic              overrun_q, overrun_d;

    logic [LFSR_W-1:0] shifted;
    logic [LFSR_W-1:0] inj;
    logic [LFSR_W-1:0] nxt;
    logic [LFSR_W-1:0] rsd;
    logic [PTR_W:0]    count;
    logic              step;
    logic              push;
    logic              pop;
    logic              full;
    logic [7:0]        push_byte;

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        warm_cnt_d = warm_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_sr_d  = byte_sr_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overrun_d  = overrun_q;
        push       = 1'b0;

        step = chaos_valid & ~reseed;

        shifted = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS_W) : (lfsr_q >> 1);
        inj = '0;
        inj[INJ_BITS-1:0] = chaos_in[INJ_BITS-1:0];
        nxt = shifted ^ inj;
        rsd = chaos_valid ? (SEED_W ^ LFSR_W'(chaos_in)) : SEED_W;
        push_byte = {byte_sr_q, nxt[0]};

        if (reseed) begin
            lfsr_d     = (rsd == '0) ? SEED_W : rsd;
            state_d    = ST_WARM;
            warm_cnt_d = '0;
            bit_cnt_d  = '0;
            byte_sr_d  = '0;
        end else if (step) begin
            // An all-zero Galois state never leaves zero, so fall back to SEED.
            lfsr_d = (nxt == '0) ? SEED_W : nxt;
            unique case (state_q)
                ST_WARM: begin
                    if (warm_cnt_q == WC_END) begin
                        state_d    = ST_RUN;
                        warm_cnt_d = '0;
                    end else begin
                        warm_cnt_d = warm_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    byte_sr_d = push_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    push      = (bit_cnt_q == 3'd7);
                end
                default: state_d = ST_WARM;
            endcase
        end

        count = wr_ptr_q - rd_ptr_q;
        full  = (count == DEPTH);
        pop   = (count != '0) & out_ready;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // A pop in the same cycle frees the slot, so a full FIFO still
        // accepts the new byte.
        if (push) begin
            if (full && !pop) begin
                overrun_d = 1'b1;
            end else begin
                mem_d[wr_ptr_q[PTR_W-1:0]] = push_byte;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_WARM;
            lfsr_q     <= SEED_W;
            warm_cnt_q <= '0;
            bit_cnt_q  <= '0;
            byte_sr_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            warm_cnt_q <= warm_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_sr_q  <= byte_sr_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overrun_q  <= overrun_d;
        end
    end

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q[PTR_W-1:0]] : 8'h00;
    assign warm      = (state_q == ST_RUN);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_chaos_lfsr_mixer.sv
// Scoreboard bench for chaos_lfsr_mixer: a behavioural model queues expected
// bytes, a monitor pops and compares them whenever the DUT hands one over.
module tb_chaos_lfsr_mixer;

    logic        clk;
    logic        rst;
    logic [15:0] chaos_in;
    logic        chaos_valid;
    logic        reseed;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        warm;
    logic        overrun;

    chaos_lfsr_mixer dut (
        .clk         (clk),
        .rst         (rst),
        .chaos_in    (chaos_in),
        .chaos_valid (chaos_valid),
        .reseed      (reseed),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .warm        (warm),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_pop  = 0;

    logic [7:0] exp_q [$];

    logic [15:0] m_lfsr;
    logic        m_run;
    int          m_wcnt;
    int          m_bcnt;
    logic [7:0]  m_sr;
    int          m_cnt;
    logic        m_ovr;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, req);
    endtask

    task automatic model_reset();
        m_lfsr = 16'hACE1;
        m_run  = 1'b0;
        m_wcnt = 0;
        m_bcnt = 0;
        m_sr   = 8'h00;
        m_cnt  = 0;
        m_ovr  = 1'b0;
        exp_q.delete();
    endtask

    function automatic logic [15:0] galois(input logic [15:0] x);
        logic [15:0] r;
        r = {1'b0, x[15:1]};
        if (x[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // Model predicts the effect of the coming rising edge from stable inputs.
    always @(negedge clk) begin
        logic        do_pop;
        logic        do_push;
        logic [7:0]  pb;
        logic [15:0] v;
        logic [15:0] nx;
        #1;
        if (rst) begin
            do_pop  = (m_cnt > 0) && out_ready;
            do_push = 1'b0;
            pb      = 8'h00;
            if (reseed) begin
                v = chaos_valid ? (16'hACE1 ^ chaos_in) : 16'hACE1;
                m_lfsr = (v == 16'h0) ? 16'hACE1 : v;
                m_run  = 1'b0;
                m_wcnt = 0;
                m_bcnt = 0;
                m_sr   = 8'h00;
            end else if (chaos_valid) begin
                nx = galois(m_lfsr) ^ {12'h000, chaos_in[3:0]};
                m_lfsr = (nx == 16'h0) ? 16'hACE1 : nx;
                if (!m_run) begin
                    m_wcnt++;
                    if (m_wcnt == 8) m_run = 1'b1;
                end else begin
                    m_sr = {m_sr[6:0], nx[0]};
                    m_bcnt++;
                    if (m_bcnt == 8) begin
                        m_bcnt  = 0;
                        do_push = 1'b1;
                        pb      = m_sr;
                    end
                end
            end
            if (do_push) begin
                if (m_cnt == 4 && !do_pop) begin
                    m_ovr = 1'b1;
                end else begin
                    exp_q.push_back(pb);
                    m_cnt++;
                end
            end
            if (do_pop) m_cnt--;
        end
    end

    // Monitor: outputs are stable at the falling edge.
    always @(negedge clk) begin
        check("out_valid", 32'(out_valid), 32'(m_cnt > 0));
        check("warm", 32'(warm), 32'(m_run));
        check("overrun", 32'(overrun), 32'(m_ovr));
        if (out_valid && out_ready) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end else if (!out_valid) begin
            check("out_data_empty", 32'(out_data), 32'h0);
        end
    end

    task automatic drive(input logic v, input logic [15:0] d,
                         input logic rs, input logic rdy);
        chaos_valid = v;
        chaos_in    = d;
        reseed      = rs;
        out_ready   = rdy;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        int pops0;
        chaos_valid = 1'b0;
        chaos_in    = 16'h0;
        reseed      = 1'b0;
        out_ready   = 1'b0;
        do_reset();

        // T1: single step from SEED with injection 3
        drive(1'b1, 16'h0003, 1'b0, 1'b0);
        check("t1_lfsr", 32'(dut.lfsr_q), 32'h0000_E273);
        check("t1_warm", 32'(warm), 32'h0);

        // T2: chaos_in=0, first byte is bits 9..16 = 8'h46
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 16'h0000, 1'b0, 1'b1);
            if (i == 7) check("t2_warm7", 32'(warm), 32'h0);
            if (i == 8) check("t2_warm8", 32'(warm), 32'h1);
            if (i == 15) check("t2_valid15", 32'(out_valid), 32'h0);
            if (i == 16) begin
                check("t2_valid16", 32'(out_valid), 32'h1);
                check("t2_byte", 32'(out_data), 32'h46);
            end
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b1);

        // T3: six bytes with no consumer; two are dropped
        for (int i = 0; i < 48; i++) begin
            drive(1'b1, 16'(i * 16'h1357), 1'b0, 1'b0);
        end
        check("t3_overrun", 32'(overrun), 32'h1);
        check("t3_valid", 32'(out_valid), 32'h1);

        // T4: reseed whose XOR is zero falls back to SEED; FIFO kept
        drive(1'b1, 16'hACE1, 1'b1, 1'b0);
        check("t4_lfsr", 32'(dut.lfsr_q), 32'h0000_ACE1);
        check("t4_warm", 32'(warm), 32'h0);
        check("t4_valid", 32'(out_valid), 32'h1);
        check("t4_overrun", 32'(overrun), 32'h1);

        pops0 = n_pop;
        for (int i = 0; i < 6; i++) drive(1'b0, 16'h0, 1'b0, 1'b1);
        check("t3_drain_cnt", 32'(n_pop - pops0), 32'd4);
        check("t3_drained", 32'(out_valid), 32'h0);
        check("t3_overrun_sticky", 32'(overrun), 32'h1);

        // T5: async reset mid-byte with two bytes queued
        for (int i = 0; i < 8 + 16 + 5; i++) begin
            drive(1'b1, 16'(i * 16'h0F0F), 1'b0, 1'b0);
        end
        check("t5_pre_valid", 32'(out_valid), 32'h1);
        rst = 1'b0;
        model_reset();
        #1;
        check("t5_valid", 32'(out_valid), 32'h0);
        check("t5_overrun", 32'(overrun), 32'h0);
        check("t5_lfsr", 32'(dut.lfsr_q), 32'h0000_ACE1);
        check("t5_warm", 32'(warm), 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b1;

        // T6: random traffic against the model
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 9) < 7, 16'($urandom),
                  $urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 8; i++) drive(1'b0, 16'h0, 1'b0, 1'b1);
        check("t6_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
